// File: rtl/br_comp_arbiter_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// br_comp_arbiter_if : request, comparator and response channels of the arbiter
// Rev 1.0
// ---------------------------------------------------------------------------
interface br_comp_arbiter_if #(
  parameter int DATA_W = 32
);
  logic [1:0]          i_req_valid;
  logic [2*DATA_W-1:0] i_req_rs1;
  logic [2*DATA_W-1:0] i_req_rs2;
  logic [5:0]          i_req_funct3;
  logic [1:0]          o_req_ready;
  logic [DATA_W-1:0]   o_cmp_rs1;
  logic [DATA_W-1:0]   o_cmp_rs2;
  logic                o_cmp_br_un;
  logic                i_cmp_less;
  logic                i_cmp_equal;
  logic                o_rsp_valid;
  logic                o_rsp_id;
  logic                o_rsp_taken;
  logic                o_rsp_err;
  logic                i_rsp_ready;

  modport slave (
    input  i_req_valid, i_req_rs1, i_req_rs2, i_req_funct3,
    output o_req_ready,
    output o_cmp_rs1, o_cmp_rs2, o_cmp_br_un,
    input  i_cmp_less, i_cmp_equal,
    output o_rsp_valid, o_rsp_id, o_rsp_taken, o_rsp_err,
    input  i_rsp_ready
  );

  modport master (
    output i_req_valid, i_req_rs1, i_req_rs2, i_req_funct3,
    input  o_req_ready,
    input  o_cmp_rs1, o_cmp_rs2, o_cmp_br_un,
    output i_cmp_less, i_cmp_equal,
    input  o_rsp_valid, o_rsp_id, o_rsp_taken, o_rsp_err,
    output i_rsp_ready
  );
endinterface
`default_nettype wire

// File: rtl/br_comp_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// br_comp_arbiter : round-robin sharing of one branch comparator by two requesters
// Rev 1.0
// ---------------------------------------------------------------------------
module br_comp_arbiter #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  wire logic          i_clk,
  input  wire logic          i_rst_n,
  br_comp_arbiter_if.slave   bus,
  output logic [CNT_W-1:0]   o_cnt_total,
  output logic [CNT_W-1:0]   o_cnt_taken
);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_CMP  = 2'b01,
    S_RESP = 2'b10
  } state_t;

  localparam logic [CNT_W-1:0] C_CNT_MAX = {CNT_W{1'b1}};

  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_ptr;
  logic [1:0]        w_grant;
  logic [DATA_W-1:0] r_rs1;
  logic [DATA_W-1:0] r_rs2;
  logic [2:0]        r_f3;
  logic              r_id;
  logic              r_taken;
  logic              r_err;
  logic              w_taken;
  logic              w_err;
  logic [CNT_W-1:0]  r_cnt_total;
  logic [CNT_W-1:0]  r_cnt_taken;

  always_comb begin
    w_state_nxt = r_state;
    w_grant     = 2'b00;
    case (r_state)
      S_IDLE: begin
        if (bus.i_req_valid[r_ptr]) begin
          w_grant[r_ptr] = 1'b1;
        end else if (bus.i_req_valid[~r_ptr]) begin
          w_grant[~r_ptr] = 1'b1;
        end
        if (w_grant != 2'b00) w_state_nxt = S_CMP;
      end
      S_CMP:   w_state_nxt = S_RESP;
      S_RESP:  if (bus.i_rsp_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
    // No grant may be advertised while reset is being applied.
    if (!i_rst_n) w_grant = 2'b00;
  end

  always_comb begin
    w_taken = 1'b0;
    w_err   = 1'b0;
    case (r_f3)
      3'b000:         w_taken = bus.i_cmp_equal;
      3'b001:         w_taken = ~bus.i_cmp_equal;
      3'b100, 3'b110: w_taken = bus.i_cmp_less;
      3'b101, 3'b111: w_taken = ~bus.i_cmp_less;
      default:        w_err   = 1'b1;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state     <= S_IDLE;
      r_ptr       <= 1'b0;
      r_rs1       <= '0;
      r_rs2       <= '0;
      r_f3        <= 3'b000;
      r_id        <= 1'b0;
      r_taken     <= 1'b0;
      r_err       <= 1'b0;
      r_cnt_total <= '0;
      r_cnt_taken <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_grant != 2'b00) begin
        r_rs1 <= bus.i_req_rs1[w_grant[1]*DATA_W +: DATA_W];
        r_rs2 <= bus.i_req_rs2[w_grant[1]*DATA_W +: DATA_W];
        r_f3  <= bus.i_req_funct3[w_grant[1]*3 +: 3];
        r_id  <= w_grant[1];
        r_ptr <= ~w_grant[1];
      end
      if (r_state == S_CMP) begin
        r_taken <= w_taken;
        r_err   <= w_err;
      end
      if (r_state == S_RESP && bus.i_rsp_ready) begin
        if (r_cnt_total != C_CNT_MAX) r_cnt_total <= r_cnt_total + CNT_W'(1);
        if (r_taken && r_cnt_taken != C_CNT_MAX) r_cnt_taken <= r_cnt_taken + CNT_W'(1);
      end
    end
  end

  assign bus.o_req_ready = w_grant;
  assign bus.o_cmp_rs1   = r_rs1;
  assign bus.o_cmp_rs2   = r_rs2;
  // Unsigned only for 110/111; the illegal 01x codes also select signed.
  assign bus.o_cmp_br_un = r_f3[2] & r_f3[1];
  assign bus.o_rsp_valid = (r_state == S_RESP);
  assign bus.o_rsp_id    = r_id;
  assign bus.o_rsp_taken = r_taken;
  assign bus.o_rsp_err   = r_err;
  assign o_cnt_total     = r_cnt_total;
  assign o_cnt_taken     = r_cnt_taken;

endmodule
`default_nettype wire

// File: tb/tb_br_comp_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_br_comp_arbiter : directed stimulus against a transaction-level arbiter model
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_br_comp_arbiter;
  localparam int DW = 32;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  br_comp_arbiter_if #(.DATA_W(DW)) bus ();
  br_comp_arbiter_if #(.DATA_W(DW)) bus_s ();

  logic [15:0] cnt_total, cnt_taken;
  logic [1:0]  s_total, s_taken;

  br_comp_arbiter #(.DATA_W(DW), .CNT_W(16)) u_dut (
    .i_clk(clk), .i_rst_n(rst_n), .bus(bus.slave),
    .o_cnt_total(cnt_total), .o_cnt_taken(cnt_taken)
  );

  // Narrow-counter copy sees identical stimulus to exercise saturation.
  br_comp_arbiter #(.DATA_W(DW), .CNT_W(2)) u_dut_sat (
    .i_clk(clk), .i_rst_n(rst_n), .bus(bus_s.slave),
    .o_cnt_total(s_total), .o_cnt_taken(s_taken)
  );

  assign bus_s.i_req_valid  = bus.i_req_valid;
  assign bus_s.i_req_rs1    = bus.i_req_rs1;
  assign bus_s.i_req_rs2    = bus.i_req_rs2;
  assign bus_s.i_req_funct3 = bus.i_req_funct3;
  assign bus_s.i_rsp_ready  = bus.i_rsp_ready;

  always_comb begin
    bus.i_cmp_equal   = (bus.o_cmp_rs1 == bus.o_cmp_rs2);
    bus.i_cmp_less    = bus.o_cmp_br_un ? (bus.o_cmp_rs1 < bus.o_cmp_rs2)
                                        : ($signed(bus.o_cmp_rs1) < $signed(bus.o_cmp_rs2));
    bus_s.i_cmp_equal = (bus_s.o_cmp_rs1 == bus_s.o_cmp_rs2);
    bus_s.i_cmp_less  = bus_s.o_cmp_br_un ? (bus_s.o_cmp_rs1 < bus_s.o_cmp_rs2)
                                          : ($signed(bus_s.o_cmp_rs1) < $signed(bus_s.o_cmp_rs2));
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Model: phase counts cycles since accept (0 idle, 1 compare, 2 response).
  int          m_phase = 0;
  logic        m_ptr = 1'b0, m_id = 1'b0, m_taken = 1'b0, m_err = 1'b0;
  logic [31:0] m_rs1 = '0, m_rs2 = '0;
  logic [2:0]  m_f3 = '0;
  int          m_total = 0, m_taken_cnt = 0;

  function automatic logic [1:0] exp_grant();
    if (!rst_n || m_phase != 0) return 2'b00;
    if (bus.i_req_valid[m_ptr])  return m_ptr ? 2'b10 : 2'b01;
    if (bus.i_req_valid[!m_ptr]) return m_ptr ? 2'b01 : 2'b10;
    return 2'b00;
  endfunction

  // Returns {err, taken} straight from the branch semantics of funct3.
  function automatic logic [1:0] outcome(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    case (f3)
      3'd0:    return {1'b0, a == b};
      3'd1:    return {1'b0, a != b};
      3'd4:    return {1'b0, $signed(a) < $signed(b)};
      3'd5:    return {1'b0, $signed(a) >= $signed(b)};
      3'd6:    return {1'b0, a < b};
      3'd7:    return {1'b0, a >= b};
      default: return 2'b10;
    endcase
  endfunction

  function automatic longint sat(input int v, input int w);
    longint mx = (longint'(1) << w) - 1;
    return (v > mx) ? mx : v;
  endfunction

  always @(posedge clk) begin : model
    logic [1:0] g;
    g = exp_grant();
    if (!rst_n) begin
      m_phase = 0; m_ptr = 0; m_id = 0; m_taken = 0; m_err = 0;
      m_rs1 = '0; m_rs2 = '0; m_f3 = '0; m_total = 0; m_taken_cnt = 0;
    end else if (m_phase == 0) begin
      if (g != 2'b00) begin
        m_id  = g[1];
        m_rs1 = bus.i_req_rs1[int'(m_id)*32 +: 32];
        m_rs2 = bus.i_req_rs2[int'(m_id)*32 +: 32];
        m_f3  = bus.i_req_funct3[int'(m_id)*3 +: 3];
        {m_err, m_taken} = outcome(m_f3, m_rs1, m_rs2);
        m_ptr   = !m_id;
        m_phase = 1;
      end
    end else if (m_phase == 1) begin
      m_phase = 2;
    end else if (bus.i_rsp_ready) begin
      m_total++;
      if (m_taken) m_taken_cnt++;
      m_phase = 0;
    end
  end

  always @(negedge clk) begin : compare
    chk("req_ready", 64'(bus.o_req_ready), 64'(exp_grant()));
    chk("cmp_rs1", 64'(bus.o_cmp_rs1), 64'(m_rs1));
    chk("cmp_rs2", 64'(bus.o_cmp_rs2), 64'(m_rs2));
    chk("cmp_br_un", 64'(bus.o_cmp_br_un), 64'(m_f3 == 3'd6 || m_f3 == 3'd7));
    chk("rsp_valid", 64'(bus.o_rsp_valid), 64'(m_phase == 2));
    if (m_phase == 2) begin
      chk("rsp_id", 64'(bus.o_rsp_id), 64'(m_id));
      chk("rsp_taken", 64'(bus.o_rsp_taken), 64'(m_taken));
      chk("rsp_err", 64'(bus.o_rsp_err), 64'(m_err));
    end
    chk("cnt_total", 64'(cnt_total), 64'(sat(m_total, 16)));
    chk("cnt_taken", 64'(cnt_taken), 64'(sat(m_taken_cnt, 16)));
    chk("sat_total", 64'(s_total), 64'(sat(m_total, 2)));
    chk("sat_taken", 64'(s_taken), 64'(sat(m_taken_cnt, 2)));
  end

  task automatic set_req(input int k, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    bus.i_req_funct3[k*3 +: 3] = f3;
    bus.i_req_rs1[k*32 +: 32]  = a;
    bus.i_req_rs2[k*32 +: 32]  = b;
    bus.i_req_valid[k]         = 1'b1;
  endtask

  task automatic wait_grant(input int k);
    bit got = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.o_req_ready[k]) begin
        got = 1;
        break;
      end
    end
    chk("grant_seen", 64'(got), 64'd1);
  endtask

  task automatic issue(input int k, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       input logic e_brun, input logic e_taken, input logic e_err);
    set_req(k, f3, a, b);
    wait_grant(k);
    @(posedge clk); #1 bus.i_req_valid[k] = 1'b0;
    @(negedge clk);
    chk("lit_br_un", 64'(bus.o_cmp_br_un), 64'(e_brun));
    @(negedge clk);
    chk("lit_rsp_valid", 64'(bus.o_rsp_valid), 64'd1);
    chk("lit_rsp_id", 64'(bus.o_rsp_id), 64'(k));
    chk("lit_rsp_taken", 64'(bus.o_rsp_taken), 64'(e_taken));
    chk("lit_rsp_err", 64'(bus.o_rsp_err), 64'(e_err));
    @(posedge clk); #1;
  endtask

  task automatic summary();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
  endtask

  initial begin : stim
    logic order [4];
    int   n;
    bus.i_req_valid  = 2'b00;
    bus.i_req_rs1    = '0;
    bus.i_req_rs2    = '0;
    bus.i_req_funct3 = '0;
    bus.i_rsp_ready  = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    issue(0, 3'b110, 32'h0000_0001, 32'hFFFF_FFFF, 1'b1, 1'b1, 1'b0);
    issue(1, 3'b100, 32'h8000_0000, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0);
    issue(1, 3'b101, 32'h8000_0000, 32'h7FFF_FFFF, 1'b0, 1'b0, 1'b0);
    issue(1, 3'b010, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    chk("lit_total_after_err", 64'(cnt_total), 64'd4);
    chk("lit_taken_after_err", 64'(cnt_taken), 64'd2);

    // Reset while a compare is in flight and both requesters stay valid.
    @(posedge clk); #1;
    set_req(0, 3'b000, 32'd5, 32'd5);
    set_req(1, 3'b001, 32'd1, 32'd2);
    wait_grant(0);
    @(posedge clk); #1 rst_n = 1'b0;
    @(negedge clk);
    chk("rst_ready", 64'(bus.o_req_ready), 64'd0);
    @(posedge clk);
    @(negedge clk);
    chk("rst_ready2", 64'(bus.o_req_ready), 64'd0);
    chk("rst_cmp", {bus.o_cmp_rs1, bus.o_cmp_rs2}, 64'd0);
    chk("rst_rsp", 64'({bus.o_cmp_br_un, bus.o_rsp_valid, bus.o_rsp_id, bus.o_rsp_taken, bus.o_rsp_err}), 64'd0);
    chk("rst_cnt", 64'({cnt_total, cnt_taken}), 64'd0);
    @(posedge clk); #1 rst_n = 1'b1;

    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.o_req_ready != 2'b00) begin
        order[n] = bus.o_req_ready[1];
        n++;
        if (n == 4) begin
          @(posedge clk); #1 bus.i_req_valid = 2'b00;
          break;
        end
      end
    end
    chk("grant_count", 64'(n), 64'd4);
    for (int i = 0; i < 4; i++) chk("grant_order", 64'(order[i]), 64'(i % 2));
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("lit_total_rr", 64'(cnt_total), 64'd4);
    chk("lit_taken_rr", 64'(cnt_taken), 64'd4);
    chk("lit_sat_total_rr", 64'(s_total), 64'd3);

    // Backpressure with the other requester waiting.
    @(posedge clk); #1;
    bus.i_rsp_ready = 1'b0;
    set_req(0, 3'b000, 32'd1, 32'd1);
    set_req(1, 3'b100, 32'd3, 32'd9);
    wait_grant(0);
    @(posedge clk); #1 bus.i_req_valid[0] = 1'b0;
    @(posedge clk);
    repeat (5) begin
      @(negedge clk);
      chk("bp_valid", 64'(bus.o_rsp_valid), 64'd1);
      chk("bp_fields", 64'({bus.o_rsp_id, bus.o_rsp_taken, bus.o_rsp_err}), 64'b010);
      chk("bp_ready", 64'(bus.o_req_ready), 64'd0);
    end
    @(posedge clk); #1;
    bus.i_req_valid = 2'b00;
    bus.i_rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("lit_total_end", 64'(cnt_total), 64'd5);
    chk("lit_taken_end", 64'(cnt_taken), 64'd5);
    chk("lit_sat_taken_end", 64'(s_taken), 64'd3);
    chk("lit_rsp_idle", 64'(bus.o_rsp_valid), 64'd0);

    repeat (2) @(posedge clk);
    summary();
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: time limit reached before end of stimulus");
    n_fail++;
    summary();
    $finish;
  end

endmodule
`default_nettype wire
